// File: rtl/gpio_config_sequencer.sv
// Serially programs the GPIO pad control chain from a per-pad config table, farthest pad first.
// Optional feature macro: GPIO_CFG_ABORT_EN adds abort/aborted to cut a sequence short without loading.
module gpio_config_sequencer #(
  parameter int NUM_GPIO = 19,
  parameter int WORD_W   = 13,
  parameter int CLK_DIV  = 4,
  localparam int AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
`ifdef GPIO_CFG_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     cfg_addr,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              serial_clock,
  output logic              serial_data,
  output logic              serial_load,
  output logic [2:0]        state_dbg
);

  // Handshake: start is a 1-cycle request honoured only in IDLE; busy rises the next cycle
  // and stays high through FINISH; done pulses for exactly one cycle in FINISH.
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_GPIO - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LOAD     = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     idx, idx_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DW-1:0]     div_cnt, div_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              sd_n;
`ifdef GPIO_CFG_ABORT_EN
  logic              abort_hit;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    bit_n   = bit_cnt;
    div_n   = div_cnt;
    shreg_n = shreg;
`ifdef GPIO_CFG_ABORT_EN
    abort_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          idx_n   = IDX_LAST;
        end
      end
      FETCH: begin
        shreg_n = cfg_data;
        bit_n   = BIT_LAST;
        div_n   = '0;
        state_n = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          shreg_n = shreg << 1;
          if (bit_cnt != '0) begin
            bit_n   = bit_cnt - 1'b1;
            state_n = SHIFT_LO;
          end else if (idx != '0) begin
            idx_n   = idx - 1'b1;
            state_n = FETCH;
          end else begin
            state_n = LOAD;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      LOAD: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = FINISH;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef GPIO_CFG_ABORT_EN
    // Abort skips LOAD entirely so the pads keep the config they already latched.
    if (abort && (state == FETCH || state == SHIFT_LO || state == SHIFT_HI)) begin
      abort_hit = 1'b1;
      state_n   = FINISH;
    end
`endif
    // Data is set up on entry to SHIFT_LO and held through SHIFT_HI.
    sd_n = ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) && shreg_n[WORD_W-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      idx          <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      shreg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_addr     <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
`ifdef GPIO_CFG_ABORT_EN
      aborted      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      bit_cnt      <= bit_n;
      div_cnt      <= div_n;
      shreg        <= shreg_n;
      busy         <= (state_n != IDLE);
      done         <= (state_n == FINISH);
      serial_clock <= (state_n == SHIFT_HI);
      serial_data  <= sd_n;
      serial_load  <= (state_n == LOAD);
      if (state_n == FETCH) cfg_addr <= idx_n;
`ifdef GPIO_CFG_ABORT_EN
      aborted      <= abort_hit;
`endif
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_gpio_config_sequencer.sv
// Bench for gpio_config_sequencer: two instances (2 pads/div 1 and 1 pad/div 4) with a bit scoreboard.
// Exercises the abort path as well when GPIO_CFG_ABORT_EN is defined.
module tb_gpio_config_sequencer;

  localparam int W  = 13;
  localparam int NA = 2;
  localparam int DA = 1;
  localparam int NB = 1;
  localparam int DB = 4;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // instance A: 2 pads, CLK_DIV=1
  logic          start_a;
  logic          busy_a, done_a, sck_a, sd_a, load_a;
  logic [0:0]    cfg_addr_a;
  logic [W-1:0]  cfg_data_a;
  logic [2:0]    state_dbg_a;
  logic [W-1:0]  tbl_a [NA];
  assign cfg_data_a = tbl_a[cfg_addr_a];

  // instance B: 1 pad, CLK_DIV=4
  logic          start_b;
  logic          busy_b, done_b, sck_b, sd_b, load_b;
  logic [0:0]    cfg_addr_b;
  logic [W-1:0]  cfg_data_b;
  logic [2:0]    state_dbg_b;

`ifdef GPIO_CFG_ABORT_EN
  logic abort_a, aborted_a, abort_b, aborted_b;
`endif

  gpio_config_sequencer #(.NUM_GPIO(NA), .WORD_W(W), .CLK_DIV(DA)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a),
`ifdef GPIO_CFG_ABORT_EN
    .abort(abort_a), .aborted(aborted_a),
`endif
    .busy(busy_a), .done(done_a), .cfg_addr(cfg_addr_a), .cfg_data(cfg_data_a),
    .serial_clock(sck_a), .serial_data(sd_a), .serial_load(load_a), .state_dbg(state_dbg_a)
  );

  gpio_config_sequencer #(.NUM_GPIO(NB), .WORD_W(W), .CLK_DIV(DB)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b),
`ifdef GPIO_CFG_ABORT_EN
    .abort(abort_b), .aborted(aborted_b),
`endif
    .busy(busy_b), .done(done_b), .cfg_addr(cfg_addr_b), .cfg_data(cfg_data_b),
    .serial_clock(sck_b), .serial_data(sd_b), .serial_load(load_b), .state_dbg(state_dbg_b)
  );

  // scoreboard state
  logic [0:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0_a  = 0;
  int rise_a  = 0;
  int loads_a = 0;
  int loads_b = 0;
  logic prev_sck_a = 1'b0, prev_sd_a = 1'b0, prev_load_a = 1'b0;
  logic prev_sck_b = 1'b0, prev_sd_b = 1'b0, prev_load_b = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, score serial bits on rising serial_clock, check protocol.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sck_a && !prev_sck_a) begin
      rise_a++;
      check("a_bit_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("a_bit", sd_a, exp_q.pop_front());
    end
    if (sck_a) check("a_sd_hold", sd_a, prev_sd_a);
    if (sck_b) check("b_sd_hold", sd_b, prev_sd_b);
    check("a_load_sck_excl", sck_a & load_a, 0);
    check("b_load_sck_excl", sck_b & load_b, 0);
    if (load_a && !prev_load_a) loads_a++;
    if (load_b && !prev_load_b) loads_b++;
    prev_sck_a = sck_a; prev_sd_a = sd_a; prev_load_a = load_a;
    prev_sck_b = sck_b; prev_sd_b = sd_b; prev_load_b = load_b;
  endtask

  task automatic push_stream_a();
    for (int i = NA - 1; i >= 0; i--)
      for (int b = W - 1; b >= 0; b--) exp_q.push_back(tbl_a[i][b]);
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    t0_a = cyc;
    check("a_busy_after_start", busy_a, 1);
  endtask

  task automatic wait_done_a(input int limit);
    int g = 0;
    while (!done_a && g < limit) begin
      tick();
      g++;
    end
    check("a_done_seen", done_a, 1);
  endtask

  task automatic finish_a(input logic pulse_fin);
    check("a_latency", cyc - t0_a + 1, 1 + NA * (1 + 2 * W * DA) + DA);
    if (pulse_fin) start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a_done_one_cycle", {done_a, busy_a}, 2'b00);
    tick();
    check("a_idle_after", {busy_a, state_dbg_a}, {1'b0, ST_IDLE});
  endtask

  task automatic run_b();
    int last_k;
    int shift_end;
    logic e_sck, e_load, e_done;
    last_k    = 1 + NB * (1 + 2 * W * DB) + DB;
    shift_end = 1 + 2 * W * DB;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      e_sck  = (k >= 2 && k <= shift_end) && ((((k - 2) / DB) % 2) == 1);
      e_load = (k > shift_end) && (k <= shift_end + DB);
      e_done = (k == last_k);
      check($sformatf("b_pins_k%0d", k), {sck_b, load_b, done_b, busy_b},
            {e_sck, e_load, e_done, 1'b1});
      if (k >= 2 && k <= shift_end) check($sformatf("b_sd_k%0d", k), sd_b, 1);
      if (k < last_k) tick();
    end
    tick();
    check("b_idle_after", {busy_b, done_b}, 2'b00);
  endtask

  initial begin
    int g;
    int l0;
    resetn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    cfg_data_b = 13'h1FFF;
    tbl_a[0] = 13'h0402;
    tbl_a[1] = 13'h1803;
`ifdef GPIO_CFG_ABORT_EN
    abort_a = 1'b0;
    abort_b = 1'b0;
`endif
    tick();
    tick();
    check("a_reset", {busy_a, done_a, sck_a, sd_a, load_a, cfg_addr_a, state_dbg_a}, 0);
    check("b_reset", {busy_b, done_b, sck_b, sd_b, load_b, cfg_addr_b, state_dbg_b}, 0);
    resetn = 1'b1;
    tick();

    // full sequence: 1803 then 0402, one load pulse, done at cycle 56
    push_stream_a();
    l0 = loads_a;
    start_pulse_a();
    wait_done_a(200);
    finish_a(1'b0);
    check("a_stream_consumed", exp_q.size(), 0);
    check("a_one_load", loads_a - l0, 1);

    // start re-pulsed mid-shift and during FINISH is ignored
    push_stream_a();
    l0 = loads_a;
    start_pulse_a();
    repeat (10) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(200);
    finish_a(1'b1);
    check("a_restart_stream_consumed", exp_q.size(), 0);
    check("a_restart_one_load", loads_a - l0, 1);

    // reset during the second word's SHIFT_HI, then a clean replay
    push_stream_a();
    l0 = loads_a;
    start_pulse_a();
    g = 0;
    while (!(state_dbg_a == ST_SHIFT_HI && cfg_addr_a == 1'b0 && sd_a) && g < 200) begin
      tick();
      g++;
    end
    check("a_reached_word2_hi", {state_dbg_a, cfg_addr_a, sd_a}, {ST_SHIFT_HI, 1'b0, 1'b1});
    #1 resetn = 1'b0;
    #1;
    check("a_async_reset", {busy_a, done_a, sck_a, sd_a, load_a, cfg_addr_a, state_dbg_a}, 0);
    check("a_no_load_before_reset", loads_a - l0, 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();
    push_stream_a();
    start_pulse_a();
    wait_done_a(200);
    finish_a(1'b0);
    check("a_replay_stream_consumed", exp_q.size(), 0);
    check("a_replay_one_load", loads_a - l0, 1);

    // single pad, CLK_DIV=4, all-ones word
    l0 = loads_b;
    run_b();
    check("b_one_load", loads_b - l0, 1);

`ifdef GPIO_CFG_ABORT_EN
    // abort while shifting bit 5 of word 0: 13 + 8 bits go out, no load
    for (int b = W - 1; b >= 0; b--) exp_q.push_back(tbl_a[1][b]);
    for (int b = W - 1; b >= 5; b--) exp_q.push_back(tbl_a[0][b]);
    l0 = rise_a;
    g = loads_a;
    start_pulse_a();
    while ((rise_a - l0) < 21 && (cyc - t0_a) < 200) tick();
    check("a_abort_point", rise_a - l0, 21);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("a_abort_finish", {done_a, aborted_a, sck_a, sd_a, load_a}, 5'b11000);
    tick();
    check("a_abort_idle", {busy_a, done_a, aborted_a}, 3'b000);
    check("a_abort_no_load", loads_a - g, 0);
    check("a_abort_stream_consumed", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
